// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, raster counters, sync/blank
// flags, line/frame strobes and a look-ahead fetch coordinate for frame-buffer reads.
module vga_timing_gen #(
  parameter int PIX_DIV = 1,
  parameter int H_AREA  = 800,
  parameter int H_FP    = 40,
  parameter int H_SYNC  = 128,
  parameter int H_BP    = 88,
  parameter int V_AREA  = 600,
  parameter int V_FP    = 1,
  parameter int V_SYNC  = 4,
  parameter int V_BP    = 23,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int LEAD    = 2,
  localparam int H_TOTAL = H_AREA + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_AREA + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic           CLK_40,
  input  logic           reset,
  input  logic           en,
  output logic           pix_en,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic [X_W-1:0] fetch_x,
  output logic [Y_W-1:0] fetch_y,
  output logic           fetch_valid
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
  // Reset fetch position is the last back-porch pixel advanced by LEAD with frame wrap.
  localparam int FX_RST = (LEAD > 0) ? LEAD - 1 : H_TOTAL - 1;
  localparam int FY_RST = (LEAD > 0) ? 0 : V_TOTAL - 1;
  localparam bit FV_RST = (FX_RST < H_AREA) && (FY_RST < V_AREA);
  localparam int HS_LO  = H_AREA + H_FP;
  localparam int HS_HI  = H_AREA + H_FP + H_SYNC;
  localparam int VS_LO  = V_AREA + V_FP;
  localparam int VS_HI  = V_AREA + V_FP + V_SYNC;

  function automatic logic in_win(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [X_W-1:0]   x_q, x_d, fx_q, fx_d;
  logic [Y_W-1:0]   y_q, y_d, fy_q, fy_d;
  logic             pix_q, ls_q, fs_q, hs_q, vs_q, blank_q, fv_q;
  logic             tick;

  assign tick = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Display and fetch pairs share the same wrap rules; only their start points differ.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fx_d = fx_q;
    fy_d = fy_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (fx_q == X_LAST) begin
        fx_d = '0;
        fy_d = (fy_q == Y_LAST) ? '0 : fy_q + 1'b1;
      end else begin
        fx_d = fx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= X_LAST;
      y_q     <= Y_LAST;
      fx_q    <= X_W'(FX_RST);
      fy_q    <= Y_W'(FY_RST);
      pix_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b1;
      fv_q    <= FV_RST;
    end else begin
      div_q <= div_d;
      pix_q <= tick;
      ls_q  <= tick && (x_d == '0);
      fs_q  <= tick && (x_d == '0) && (y_d == '0);
      // Flags come from the next-state counters so they align with the new position.
      if (tick) begin
        x_q     <= x_d;
        y_q     <= y_d;
        fx_q    <= fx_d;
        fy_q    <= fy_d;
        hs_q    <= in_win(int'(x_d), HS_LO, HS_HI) ? HS_POL : ~HS_POL;
        vs_q    <= in_win(int'(y_d), VS_LO, VS_HI) ? VS_POL : ~VS_POL;
        blank_q <= !(in_win(int'(x_d), 0, H_AREA) && in_win(int'(y_d), 0, V_AREA));
        fv_q    <= in_win(int'(fx_d), 0, H_AREA) && in_win(int'(fy_d), 0, V_AREA);
      end
    end
  end

  assign pix_en      = pix_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = blank_q;
  assign active      = ~blank_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign fetch_valid = fv_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 instance plus a small PIX_DIV=3 instance,
// table vectors, pulse-spacing sequences and random en/reset against a raster-index model.
module tb_vga_timing_gen;

  localparam int AXW = 11, AYW = 10;
  localparam int BXW = 4,  BYW = 3;

  typedef struct {
    int pd, ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lead;
  } cfg_t;

  typedef struct {
    int pix, x, y, hs, vs, blank, active, ls, fs, fx, fy, fv;
  } obs_t;

  typedef struct {
    bit rst; bit en; int n;
    int x, y, b, hs, vs, pix, ls, fs, fx, fy, fv;
  } vec_t;

  logic CLK_40 = 1'b0;
  always #5 CLK_40 = ~CLK_40;

  logic rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
  logic pix_a, hs_a, vs_a, bl_a, ac_a, ls_a, fs_a, fv_a;
  logic [AXW-1:0] x_a, fx_a;
  logic [AYW-1:0] y_a, fy_a;
  logic pix_b, hs_b, vs_b, bl_b, ac_b, ls_b, fs_b, fv_b;
  logic [BXW-1:0] x_b, fx_b;
  logic [BYW-1:0] y_b, fy_b;

  vga_timing_gen dut_a (
    .CLK_40(CLK_40), .reset(rst_a), .en(en_a), .pix_en(pix_a),
    .x_pos(x_a), .y_pos(y_a), .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .active(ac_a),
    .line_start(ls_a), .frame_start(fs_a), .fetch_x(fx_a), .fetch_y(fy_a),
    .fetch_valid(fv_a)
  );

  vga_timing_gen #(
    .PIX_DIV(3), .H_AREA(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_AREA(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(3)
  ) dut_b (
    .CLK_40(CLK_40), .reset(rst_b), .en(en_b), .pix_en(pix_b),
    .x_pos(x_b), .y_pos(y_b), .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .active(ac_b),
    .line_start(ls_b), .frame_start(fs_b), .fetch_x(fx_b), .fetch_y(fy_b),
    .fetch_valid(fv_b)
  );

  obs_t obs [2];
  always_comb begin
    obs[0].pix = int'(pix_a); obs[0].x = int'(x_a); obs[0].y = int'(y_a);
    obs[0].hs = int'(hs_a); obs[0].vs = int'(vs_a); obs[0].blank = int'(bl_a);
    obs[0].active = int'(ac_a); obs[0].ls = int'(ls_a); obs[0].fs = int'(fs_a);
    obs[0].fx = int'(fx_a); obs[0].fy = int'(fy_a); obs[0].fv = int'(fv_a);
    obs[1].pix = int'(pix_b); obs[1].x = int'(x_b); obs[1].y = int'(y_b);
    obs[1].hs = int'(hs_b); obs[1].vs = int'(vs_b); obs[1].blank = int'(bl_b);
    obs[1].active = int'(ac_b); obs[1].ls = int'(ls_b); obs[1].fs = int'(fs_b);
    obs[1].fx = int'(fx_b); obs[1].fy = int'(fy_b); obs[1].fv = int'(fv_b);
  end

  int checks = 0, failures = 0;
  cfg_t cfgs [2];
  int pm [2];
  int cm [2];
  bit pl [2];

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the raster is a linear pixel index p over the whole frame.
  function automatic obs_t expect_of(input cfg_t c, input int p, input bit pulse);
    obs_t e;
    int ht, vt, tot, fp;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    tot = ht * vt;
    e.x = p % ht;
    e.y = p / ht;
    e.hs = (e.x >= c.ha + c.hf && e.x < c.ha + c.hf + c.hs) ? c.hp : 1 - c.hp;
    e.vs = (e.y >= c.va + c.vf && e.y < c.va + c.vf + c.vs) ? c.vp : 1 - c.vp;
    e.blank = (e.x < c.ha && e.y < c.va) ? 0 : 1;
    e.active = 1 - e.blank;
    fp = (p + c.lead) % tot;
    e.fx = fp % ht;
    e.fy = fp / ht;
    e.fv = (e.fx < c.ha && e.fy < c.va) ? 1 : 0;
    e.pix = int'(pulse);
    e.ls = (pulse && e.x == 0) ? 1 : 0;
    e.fs = (pulse && p == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic en);
    cfg_t c;
    int tot;
    c = cfgs[d];
    tot = (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
    if (rst) begin
      pm[d] = tot - 1; cm[d] = 0; pl[d] = 1'b0;
    end else if (en) begin
      if (cm[d] == c.pd - 1) begin
        cm[d] = 0; pm[d] = (pm[d] + 1) % tot; pl[d] = 1'b1;
      end else begin
        cm[d]++; pl[d] = 1'b0;
      end
    end else begin
      pl[d] = 1'b0;
    end
  endtask

  task automatic check_model(input int d);
    obs_t e, o;
    string pre;
    pre = (d == 0) ? "mdl_a_" : "mdl_b_";
    e = expect_of(cfgs[d], pm[d], pl[d]);
    o = obs[d];
    cmp({pre, "pix_en"}, o.pix, e.pix);
    cmp({pre, "x"}, o.x, e.x);
    cmp({pre, "y"}, o.y, e.y);
    cmp({pre, "hsync"}, o.hs, e.hs);
    cmp({pre, "vsync"}, o.vs, e.vs);
    cmp({pre, "blank"}, o.blank, e.blank);
    cmp({pre, "active"}, o.active, e.active);
    cmp({pre, "line_start"}, o.ls, e.ls);
    cmp({pre, "frame_start"}, o.fs, e.fs);
    cmp({pre, "fetch_x"}, o.fx, e.fx);
    cmp({pre, "fetch_y"}, o.fy, e.fy);
    cmp({pre, "fetch_valid"}, o.fv, e.fv);
  endtask

  task automatic cycle();
    @(posedge CLK_40);
    model_step(0, rst_a, en_a);
    model_step(1, rst_b, en_b);
    #1;
    check_model(0);
    check_model(1);
  endtask

  function automatic bit sel(input obs_t o, input int s);
    case (s)
      0: return o.pix != 0;
      1: return o.ls != 0;
      default: return o.fs != 0;
    endcase
  endfunction

  // Cycles between two consecutive pulses of the chosen strobe; -1 if the bound expires.
  task automatic pulse_gap(input int d, input int s, input int limit, output int g);
    int k;
    g = -1;
    k = 0;
    while (!sel(obs[d], s) && k < limit) begin cycle(); k++; end
    if (sel(obs[d], s)) begin
      k = 0;
      do begin cycle(); k++; end while (!sel(obs[d], s) && k < limit);
      if (sel(obs[d], s)) g = k;
    end
  endtask

  vec_t tbl [$];

  initial begin
    int g, cnt;
    cfgs[0] = '{1, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 2};
    cfgs[1] = '{3, 8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 3};

    //               rst en  n    x     y    b hs vs pix ls fs  fx   fy fv
    tbl.push_back('{1, 0, 2,   1055, 627, 1, 0, 0, 0, 0, 0, 1,    0, 1});
    tbl.push_back('{0, 1, 1,   0,    0,   0, 0, 0, 1, 1, 1, 2,    0, 1});
    tbl.push_back('{0, 1, 797, 797,  0,   0, 0, 0, 1, 0, 0, 799,  0, 1});
    tbl.push_back('{0, 1, 1,   798,  0,   0, 0, 0, 1, 0, 0, 800,  0, 0});
    tbl.push_back('{0, 1, 2,   800,  0,   1, 0, 0, 1, 0, 0, 802,  0, 0});
    tbl.push_back('{0, 1, 39,  839,  0,   1, 0, 0, 1, 0, 0, 841,  0, 0});
    tbl.push_back('{0, 1, 1,   840,  0,   1, 1, 0, 1, 0, 0, 842,  0, 0});
    tbl.push_back('{0, 1, 127, 967,  0,   1, 1, 0, 1, 0, 0, 969,  0, 0});
    tbl.push_back('{0, 1, 1,   968,  0,   1, 0, 0, 1, 0, 0, 970,  0, 0});
    tbl.push_back('{0, 1, 86,  1054, 0,   1, 0, 0, 1, 0, 0, 0,    1, 1});
    tbl.push_back('{0, 1, 1,   1055, 0,   1, 0, 0, 1, 0, 0, 1,    1, 1});
    tbl.push_back('{0, 1, 1,   0,    1,   0, 0, 0, 1, 1, 0, 2,    1, 1});
    tbl.push_back('{0, 1, 300, 300,  1,   0, 0, 0, 1, 0, 0, 302,  1, 1});
    tbl.push_back('{0, 0, 10,  300,  1,   0, 0, 0, 0, 0, 0, 302,  1, 1});
    tbl.push_back('{0, 1, 1,   301,  1,   0, 0, 0, 1, 0, 0, 303,  1, 1});
    tbl.push_back('{0, 1, 199, 500,  1,   0, 0, 0, 1, 0, 0, 502,  1, 1});
    tbl.push_back('{1, 1, 1,   1055, 627, 1, 0, 0, 0, 0, 0, 1,    0, 1});

    foreach (tbl[i]) begin
      rst_a = tbl[i].rst;
      en_a  = tbl[i].en;
      repeat (tbl[i].n) cycle();
      cmp($sformatf("tbl%0d_x", i), obs[0].x, tbl[i].x);
      cmp($sformatf("tbl%0d_y", i), obs[0].y, tbl[i].y);
      cmp($sformatf("tbl%0d_blank", i), obs[0].blank, tbl[i].b);
      cmp($sformatf("tbl%0d_active", i), obs[0].active, 1 - tbl[i].b);
      cmp($sformatf("tbl%0d_hsync", i), obs[0].hs, tbl[i].hs);
      cmp($sformatf("tbl%0d_vsync", i), obs[0].vs, tbl[i].vs);
      cmp($sformatf("tbl%0d_pix_en", i), obs[0].pix, tbl[i].pix);
      cmp($sformatf("tbl%0d_line_start", i), obs[0].ls, tbl[i].ls);
      cmp($sformatf("tbl%0d_frame_start", i), obs[0].fs, tbl[i].fs);
      cmp($sformatf("tbl%0d_fetch_x", i), obs[0].fx, tbl[i].fx);
      cmp($sformatf("tbl%0d_fetch_y", i), obs[0].fy, tbl[i].fy);
      cmp($sformatf("tbl%0d_fetch_valid", i), obs[0].fv, tbl[i].fv);
    end

    // Default timing: line period and hsync width in pixels.
    rst_a = 1'b0; en_a = 1'b1;
    pulse_gap(0, 1, 3000, g);
    cmp("a_line_period", g, 1056);
    cnt = 0;
    for (int k = 0; k < 1056; k++) begin
      cycle();
      if (obs[0].pix != 0 && obs[0].hs != 0) cnt++;
    end
    cmp("a_hsync_pixels", cnt, 128);
    rst_a = 1'b1; en_a = 1'b0;

    // Small config: pixel, line and frame periods, active-low sync widths.
    rst_b = 1'b1; en_b = 1'b0;
    cycle();
    rst_b = 1'b0; en_b = 1'b1;
    pulse_gap(1, 0, 20, g);
    cmp("b_pix_period", g, 3);
    pulse_gap(1, 1, 200, g);
    cmp("b_line_period", g, 42);
    cnt = 0;
    for (int k = 0; k < 42; k++) begin
      cycle();
      if (obs[1].pix != 0 && obs[1].hs == 0) cnt++;
    end
    cmp("b_hsync_low_pixels", cnt, 2);
    pulse_gap(1, 2, 1000, g);
    cmp("b_frame_period", g, 294);
    cnt = 0;
    for (int k = 0; k < 294; k++) begin
      cycle();
      if (obs[1].ls != 0 && obs[1].vs == 0) begin
        cnt++;
        cmp("b_vsync_line", obs[1].y, 5);
      end
    end
    cmp("b_vsync_low_lines", cnt, 1);

    // Random enable gaps and occasional mid-frame resets on both instances.
    for (int k = 0; k < 4000; k++) begin
      rst_a = ($urandom_range(0, 199) == 0);
      en_a  = ($urandom_range(0, 4) != 0);
      rst_b = ($urandom_range(0, 149) == 0);
      en_b  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It replaces the separate pixel-enable divider and hsync/vsync generators with one block. It owns the pixel-enable divider, the x/y raster counters, sync pulses with programmable polarity, blank/active flags and line/frame strobes. It also provides a look-ahead fetch coordinate, so frame-buffer reads with LEAD pixels of latency land aligned with the displayed pixel.

Parameters:
PIX_DIV, 1, CLK_40 cycles per pixel (1 gives 40 MHz for 800x600@60; must be >= 1)
H_AREA, 800, active pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_AREA, 600, active lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync
LEAD, 2, pixels by which the fetch coordinate leads the display coordinate; 0 <= LEAD <= H_FP+H_SYNC+H_BP
H_TOTAL (derived), H_AREA+H_FP+H_SYNC+H_BP
V_TOTAL (derived), V_AREA+V_FP+V_SYNC+V_BP
X_W (derived), $clog2(H_TOTAL)
Y_W (derived), $clog2(V_TOTAL)

Ports:
CLK_40  in  1  system clock; reset is synchronous, active-high, on CLK_40
reset  in  1  synchronous active-high reset
en  in  1  run enable; 0 freezes divider, counters and all outputs
pix_en  out  1  one-CLK_40 pulse per pixel
x_pos  out  X_W  displayed pixel column
y_pos  out  Y_W  displayed line
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
blank  out  1  1 outside the active area
active  out  1  ~blank
line_start  out  1  pulse when x_pos becomes 0
frame_start  out  1  pulse when (x_pos,y_pos) becomes (0,0)
fetch_x  out  X_W  column LEAD pixels ahead of x_pos
fetch_y  out  Y_W  line of the fetch position
fetch_valid  out  1  fetch position lies inside the active area

Behaviour:
- All outputs are registered. hsync/vsync/blank/active/fetch_* describe the current x_pos/y_pos with zero relative skew; they are computed from next-state counter values.
- Reset values: x_pos=H_TOTAL-1, y_pos=V_TOTAL-1 (last back-porch pixel); blank=1, active=0; hsync=~HS_POL, vsync=~VS_POL; pix_en=0, line_start=0, frame_start=0; divider=0. fetch position = display position + LEAD pixels with frame wrap, so the reset fetch value is (LEAD-1,0) for LEAD>0, else (H_TOTAL-1,V_TOTAL-1). fetch_valid per that position.
- Divider: counts 0..PIX_DIV-1 while en=1. An internal tick fires when count==PIX_DIV-1. For PIX_DIV=1 the tick fires every cycle.
- Output register update:
  - The registered outputs (x_pos, y_pos, hsync, vsync, blank, active, fetch_*) change only on the CLK_40 edge at which the tick fires.
  - pix_en and line_start/frame_start are one-cycle pulses asserted in exactly that cycle.
  - Consequence: the first pix_en after reset release comes PIX_DIV cycles later and presents (0,0) with line_start=frame_start=1.
- Counters: x increments each tick; at H_TOTAL-1 x wraps to 0 and y increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- hsync = HS_POL iff H_AREA+H_FP <= x < H_AREA+H_FP+H_SYNC. vsync = VS_POL iff V_AREA+V_FP <= y < V_AREA+V_FP+V_SYNC; vsync edges coincide with x=0.
- blank = ~(x<H_AREA && y<V_AREA).
- Fetch pair: advances in lockstep with the display pair using identical wrap rules, offset by LEAD. fetch_valid = fetch_x<H_AREA && fetch_y<V_AREA.
- en=0: divider, counters and all registered outputs hold; pix_en/line_start/frame_start forced 0. On re-enable, counting resumes from the held divider value with no skipped pixel.
- Reset mid-frame overrides en and returns every state and output to the reset values on the next edge.
- Widths: all comparisons are unsigned at X_W/Y_W. Counters never exceed H_TOTAL-1/V_TOTAL-1.

Test Plan:
- Reset release, defaults, en=1 -> first pix_en on cycle 1 with x=0, y=0, frame_start=1, blank=0; before that x=1055, y=627, blank=1, hsync=vsync=0.
- Defaults, one line -> hsync=1 for exactly 128 pix_en pulses starting at x=840; blank rises at x=800; line_start every 1056 cycles.
- Defaults, full frame -> frame_start pulses exactly 663168 cycles apart; vsync=1 for 4 lines (y=601..604), rising at x=0.
- PIX_DIV=3, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=0 -> pix_en every 3rd cycle; line length 42 cycles, frame length 294 cycles; hsync low for x=10..11, vsync low for y=5.
- LEAD=2, defaults -> fetch_x==x_pos+2 mid-line; at x=1054, fetch=(0,y+1); at (1055,627), fetch=(1,0); fetch_valid rises at x=1054 of line 627.
- en low for 10 cycles mid-line at x=300, then reset pulsed at x=500 -> outputs hold during en=0 with no pix_en and x continues at 301; the reset returns x=1055, y=627, blank=1 on the next edge.
